// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions. The sequential multiplier and divider FSMs
// use the same state encoding.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } arith_state_e;

endpackage

// File: rtl/seq_mul_add_shift.sv
// One shift-and-add step: conditionally add M into A on Q[0], then shift {C,A,Q} right by one.
// Purely combinational so a multiply-accumulate block can reuse it.
module seq_mul_add_shift #(
    parameter int G_WIDTH = 12
) (
    input  logic [G_WIDTH-1:0] a,
    input  logic [G_WIDTH-1:0] q,
    input  logic [G_WIDTH-1:0] m,
    output logic [G_WIDTH-1:0] a_next,
    output logic [G_WIDTH-1:0] q_next
);

    logic [G_WIDTH:0] sum;

    always_comb begin
        sum    = {1'b0, a} + (q[0] ? {1'b0, m} : '0);
        // Carry lands in A's MSB and A's LSB moves into Q's MSB.
        a_next = sum[G_WIDTH:1];
        q_next = {sum[0], q[G_WIDTH-1:1]};
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per clock, LSB first.
// start/busy/done handshake; the full 2*G_WIDTH-bit product is held until the next accepted start.
module seq_multiplier
    import arith_pkg::*;
#(
    parameter int G_WIDTH = 12
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic                   i_Start,
    input  logic [G_WIDTH-1:0]     i_Multiplicand,
    input  logic [G_WIDTH-1:0]     i_Multiplier,
    output logic [2*G_WIDTH-1:0]   o_Product,
    output logic                   o_Busy,
    output logic                   o_Done
);

    localparam int CNT_W = $clog2(G_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(G_WIDTH - 1);

    arith_state_e          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [G_WIDTH-1:0]    m_q, m_d;
    logic [G_WIDTH-1:0]    a_q, a_d;
    logic [G_WIDTH-1:0]    q_q, q_d;
    logic [2*G_WIDTH-1:0]  prod_q, prod_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [G_WIDTH-1:0]    a_nx, q_nx;

    seq_mul_add_shift #(.G_WIDTH(G_WIDTH)) u_step (
        .a      (a_q),
        .q      (q_q),
        .m      (m_q),
        .a_next (a_nx),
        .q_next (q_nx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        prod_d  = prod_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            // DONE accepts a start just like IDLE, which allows back-to-back operations.
            ST_IDLE, ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (i_Start) begin
                    m_d     = i_Multiplicand;
                    q_d     = i_Multiplier;
                    a_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d   = a_nx;
                q_d   = q_nx;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    prod_d  = {a_nx, q_nx};
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_Product = prod_q;
    assign o_Busy    = busy_q;
    assign o_Done    = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random bench for seq_multiplier: each start pushes A*B into a queue,
// and each o_Done pops the queue and checks the product, latency and handshake.
module tb_seq_multiplier;

    localparam int W  = 12;
    localparam int PW = 2 * W;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  mcand;
    logic [W-1:0]  mplier;
    logic [PW-1:0] product;
    logic          busy;
    logic          done;

    logic [PW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fails  = 0;
    int            cyc      = 0;
    int            start_cyc;
    int            done_cyc;
    int            busy_seen;

    seq_multiplier #(.G_WIDTH(W)) dut (
        .i_Clk          (clk),
        .i_Rst_n        (rst_n),
        .i_Start        (start),
        .i_Multiplicand (mcand),
        .i_Multiplier   (mplier),
        .o_Product      (product),
        .o_Busy         (busy),
        .o_Done         (done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // driver: one-cycle start, operands scrambled afterwards to prove they were latched
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        exp_q.push_back(PW'(a) * PW'(b));
        @(posedge clk);
        start_cyc = cyc;
        #1;
        start  = 1'b0;
        mcand  = W'($urandom);
        mplier = W'($urandom);
    endtask

    // scoreboard: wait (bounded) for o_Done, then pop and compare
    task automatic wait_done(input string tag);
        bit found;
        found     = 1'b0;
        busy_seen = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (done) found = 1'b1;
            else if (busy) busy_seen++;
        end
        if (!found) begin
            check({tag, " done timeout"}, 48'(done), 48'd1);
        end else begin
            done_cyc = cyc;
            check({tag, " busy with done"}, 48'(busy), 48'd0);
            if (exp_q.size() == 0)
                check({tag, " unexpected done"}, 48'(done), 48'd0);
            else
                check({tag, " product"}, 48'(product), 48'(exp_q.pop_front()));
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        start_op(a, b);
        wait_done(tag);
        check({tag, " latency"}, 48'(done_cyc - start_cyc - 1), 48'd12);
        check({tag, " busy cycles"}, 48'(busy_seen), 48'd12);
        @(negedge clk);
        check({tag, " done pulse width"}, 48'(done), 48'd0);
        check({tag, " product hold"}, 48'(product), 48'(PW'(a) * PW'(b)));
    endtask

    initial begin
        int d1;
        int bad;
        rst_n  = 1'b0;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        #12;
        check("reset product", 48'(product), 48'd0);
        check("reset busy", 48'(busy), 48'd0);
        check("reset done", 48'(done), 48'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(12, 10, "t1 12x10");
        do_op(4095, 4095, "t2 max x max");
        do_op(4095, 1, "t2 max x 1");
        do_op(0, 1234, "t3 0 x 1234");
        do_op(1234, 0, "t3 1234 x 0");

        // start pulses and operand changes during RUN must be ignored
        start_op(7, 9);
        repeat (4) @(negedge clk);
        start  = 1'b1;
        mcand  = 100;
        mplier = 100;
        @(negedge clk);
        mcand  = 12'hABC;
        mplier = 12'h555;
        @(negedge clk);
        start  = 1'b0;
        wait_done("t4 7x9");
        check("t4 latency", 48'(done_cyc - start_cyc - 1), 48'd12);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || product !== 24'd63) bad++;
        end
        check("t4 no second done, product held", 48'(bad), 48'd0);

        // asynchronous reset mid-RUN aborts the operation
        @(negedge clk);
        start  = 1'b1;
        mcand  = 55;
        mplier = 66;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("t5 busy before reset", 48'(busy), 48'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t5 async product", 48'(product), 48'd0);
        check("t5 async busy", 48'(busy), 48'd0);
        check("t5 async done", 48'(done), 48'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        check("t5 no done after abort", 48'(bad), 48'd0);
        do_op(3, 5, "t5 3x5");

        // start held high: back-to-back operations from the DONE cycle
        @(negedge clk);
        start  = 1'b1;
        mcand  = 2;
        mplier = 3;
        exp_q.push_back(24'd6);
        @(posedge clk);
        start_cyc = cyc;
        wait_done("t6 first");
        check("t6 first latency", 48'(done_cyc - start_cyc - 1), 48'd12);
        d1     = done_cyc;
        mcand  = 5;
        mplier = 6;
        exp_q.push_back(24'd30);
        wait_done("t6 second");
        check("t6 done period", 48'(done_cyc - d1), 48'd13);
        check("t6 busy cycles", 48'(busy_seen), 48'd12);
        start = 1'b0;
        @(negedge clk);
        check("t6 idle done", 48'(done), 48'd0);
        check("t6 idle busy", 48'(busy), 48'd0);

        for (int i = 0; i < 1000; i++)
            do_op(W'($urandom), W'($urandom), "rand");

        check("scoreboard drained", 48'(exp_q.size()), 48'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
